// File: rtl/rvfi_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_tracker_pkg
// Description : Shared types, opcode constants and the self-loop classifier
//               used by the RVFI commit tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package rvfi_tracker_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    HUNG = 2'd2
  } tracker_state_e;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // A control transfer that targets itself: the software halt idiom.
  function automatic logic is_self_loop(input logic [31:0] inst,
                                        input logic [31:0] pc_r,
                                        input logic [31:0] pc_w);
    return (pc_w == pc_r) && ((inst[6:0] == OP_JAL) || (inst[6:0] == OP_BRANCH));
  endfunction

endpackage
`default_nettype wire

// File: rtl/commit_prefix_scan.sv
`default_nettype none
// ============================================================================
// Module      : commit_prefix_scan
// Description : Combinational per-slot prefix popcount of the retirement
//               bundle, prefix-legality check, and halt-point detection that
//               drops every slot younger than the halting instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module commit_prefix_scan
  import rvfi_tracker_pkg::*;
#(
  parameter int NCOMMIT     = 2,
  parameter int HALT_REPEAT = 2,
  parameter int CNT_W       = 2,
  parameter int HC_W        = 2
) (
  input  logic [NCOMMIT-1:0]            valid_i,
  input  logic [NCOMMIT-1:0]            self_loop_i,
  input  logic [HC_W-1:0]               halt_cnt_i,
  output logic [NCOMMIT-1:0][CNT_W-1:0] prefix_cnt_o,
  output logic [NCOMMIT-1:0]            keep_o,
  output logic [CNT_W-1:0]              keep_cnt_o,
  output logic                          prefix_ok_o,
  output logic                          halt_hit_o,
  output logic [HC_W-1:0]               halt_cnt_o
);

  logic [HC_W-1:0]  w_cnt;
  logic [CNT_W-1:0] w_pop;

  // A legal bundle is a run of ones from slot 0: adding one must clear them all.
  assign prefix_ok_o = ~|(valid_i & (valid_i + NCOMMIT'(1)));

  // Oldest-to-youngest scan; once the halt point is hit, younger slots are not kept.
  always_comb begin
    prefix_cnt_o = '0;
    keep_o       = '0;
    keep_cnt_o   = '0;
    halt_hit_o   = 1'b0;
    w_cnt        = halt_cnt_i;
    w_pop        = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      prefix_cnt_o[i] = w_pop;
      if (valid_i[i]) begin
        w_pop = w_pop + CNT_W'(1);
        if (!halt_hit_o) begin
          keep_o[i]  = 1'b1;
          keep_cnt_o = keep_cnt_o + CNT_W'(1);
          if (self_loop_i[i]) begin
            if (w_cnt < HC_W'(HALT_REPEAT)) w_cnt = w_cnt + HC_W'(1);
            if (w_cnt == HC_W'(HALT_REPEAT)) halt_hit_o = 1'b1;
          end else begin
            w_cnt = '0;
          end
        end
      end
    end
    halt_cnt_o = w_cnt;
  end

endmodule
`default_nettype wire

// File: rtl/rvfi_commit_tracker.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_commit_tracker
// Description : Multi-slot RVFI commit sequencer. Assigns monotonic order
//               numbers to up to NCOMMIT retirements per cycle, detects the
//               self-loop halt idiom, flags commit-stall deadlock and checks
//               in-order slot usage.
// Revision    : 1.0 - initial release
// ============================================================================
module rvfi_commit_tracker
  import rvfi_tracker_pkg::*;
#(
  parameter int NCOMMIT     = 2,
  parameter int ORDER_W     = 64,
  parameter int HALT_REPEAT = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NCOMMIT-1:0]                valid_i,
  input  logic [NCOMMIT-1:0][31:0]          inst_i,
  input  logic [NCOMMIT-1:0][31:0]          pc_rdata_i,
  input  logic [NCOMMIT-1:0][31:0]          pc_wdata_i,
  output logic [NCOMMIT-1:0]                commit_o,
  output logic [NCOMMIT-1:0][ORDER_W-1:0]   order_o,
  output logic                              halt_o,
  output logic                              deadlock_o,
  output logic                              proto_err_o,
  output logic [ORDER_W-1:0]                retired_o
);

  localparam int CNT_W  = $clog2(NCOMMIT + 1);
  localparam int HC_W   = $clog2(HALT_REPEAT + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  tracker_state_e r_state, w_state_nxt;

  logic [ORDER_W-1:0]            r_base;
  logic [HC_W-1:0]               r_halt_cnt;
  logic [IDLE_W-1:0]             r_idle_cnt;
  logic [IDLE_W-1:0]             w_idle_nxt;
  logic [NCOMMIT-1:0]            w_self_loop;
  logic [NCOMMIT-1:0][CNT_W-1:0] w_prefix_cnt;
  logic [NCOMMIT-1:0]            w_keep;
  logic [CNT_W-1:0]              w_keep_cnt;
  logic                          w_prefix_ok;
  logic                          w_halt_hit;
  logic [HC_W-1:0]               w_halt_cnt_nxt;
  logic                          w_run;
  logic                          w_timeout;

  for (genvar g = 0; g < NCOMMIT; g++) begin : g_slot
    assign w_self_loop[g] = valid_i[g] & is_self_loop(inst_i[g], pc_rdata_i[g], pc_wdata_i[g]);
  end

  commit_prefix_scan #(
    .NCOMMIT     (NCOMMIT),
    .HALT_REPEAT (HALT_REPEAT),
    .CNT_W       (CNT_W),
    .HC_W        (HC_W)
  ) u_scan (
    .valid_i      (valid_i),
    .self_loop_i  (w_self_loop),
    .halt_cnt_i   (r_halt_cnt),
    .prefix_cnt_o (w_prefix_cnt),
    .keep_o       (w_keep),
    .keep_cnt_o   (w_keep_cnt),
    .prefix_ok_o  (w_prefix_ok),
    .halt_hit_o   (w_halt_hit),
    .halt_cnt_o   (w_halt_cnt_nxt)
  );

  assign w_run     = (r_state == RUN);
  assign retired_o = r_base;

  // Watchdog next value: any retirement clears it, otherwise saturating count.
  always_comb begin
    w_idle_nxt = r_idle_cnt;
    if (valid_i != '0)
      w_idle_nxt = '0;
    else if (r_idle_cnt != IDLE_W'(TIMEOUT))
      w_idle_nxt = r_idle_cnt + IDLE_W'(1);
  end

  assign w_timeout = (w_idle_nxt == IDLE_W'(TIMEOUT));

  // Next-state: halt takes priority over timeout; HALT and HUNG are terminal.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == RUN) begin
      if (w_halt_hit)     w_state_nxt = HALT;
      else if (w_timeout) w_state_nxt = HUNG;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  // Counters, sticky flags and the registered commit/order outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base      <= '0;
      r_halt_cnt  <= '0;
      r_idle_cnt  <= '0;
      commit_o    <= '0;
      order_o     <= '0;
      halt_o      <= 1'b0;
      deadlock_o  <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      commit_o <= w_run ? w_keep : '0;
      if (w_run) begin
        for (int i = 0; i < NCOMMIT; i++)
          order_o[i] <= r_base + ORDER_W'(w_prefix_cnt[i]);
        r_base     <= r_base + ORDER_W'(w_keep_cnt);
        r_halt_cnt <= w_halt_cnt_nxt;
        r_idle_cnt <= w_idle_nxt;
        if (!w_prefix_ok) proto_err_o <= 1'b1;
        if (w_halt_hit)     halt_o     <= 1'b1;
        else if (w_timeout) deadlock_o <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rvfi_commit_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvfi_commit_tracker
// Description : Self-checking bench: directed scenarios plus randomized
//               bundles compared against a behavioural retirement model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvfi_commit_tracker;

  localparam int NC = 2;
  localparam int OW = 8;
  localparam int HR = 2;
  localparam int TO = 16;

  localparam logic [31:0] I_ADDI = 32'h00100093;
  localparam logic [31:0] I_JAL  = 32'h0000006F;
  localparam logic [31:0] I_BEQ  = 32'h00000063;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NC-1:0]          valid_i = '0;
  logic [NC-1:0][31:0]    inst_i = '0;
  logic [NC-1:0][31:0]    pc_rdata_i = '0;
  logic [NC-1:0][31:0]    pc_wdata_i = '0;
  logic [NC-1:0]          commit_o;
  logic [NC-1:0][OW-1:0]  order_o;
  logic                   halt_o, deadlock_o, proto_err_o;
  logic [OW-1:0]          retired_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_mode;     // 0 running, 1 halted, 2 hung
  int m_next;
  int m_streak;
  int m_idle;
  bit m_halt, m_dead, m_proto;

  always #5 clk = ~clk;

  rvfi_commit_tracker #(
    .NCOMMIT(NC), .ORDER_W(OW), .HALT_REPEAT(HR), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .inst_i(inst_i),
    .pc_rdata_i(pc_rdata_i), .pc_wdata_i(pc_wdata_i), .commit_o(commit_o),
    .order_o(order_o), .halt_o(halt_o), .deadlock_o(deadlock_o),
    .proto_err_o(proto_err_o), .retired_o(retired_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // kind: 0 ADDI, 1 JAL self-loop, 2 BEQ self-loop, 3 JAL forward, 4 BEQ forward
  task automatic set_slot(input int s, input int kind, input logic [31:0] pc);
    pc_rdata_i[s] = pc;
    pc_wdata_i[s] = pc + 32'd4;
    case (kind)
      1: begin inst_i[s] = I_JAL; pc_wdata_i[s] = pc; end
      2: begin inst_i[s] = I_BEQ; pc_wdata_i[s] = pc; end
      3: inst_i[s] = I_JAL;
      4: inst_i[s] = I_BEQ;
      default: inst_i[s] = I_ADDI;
    endcase
  endtask

  // One clock: predict from the model, advance the DUT, compare everything.
  task automatic cycle();
    logic [NC-1:0] ec;
    int            eo[NC];
    int            seen, taken;
    bit            stop, gap, loop;
    ec = '0;
    for (int s = 0; s < NC; s++) eo[s] = 0;
    if (rst) begin
      m_mode = 0; m_next = 0; m_streak = 0; m_idle = 0;
      m_halt = 0; m_dead = 0; m_proto = 0;
    end else if (m_mode == 0) begin
      seen = 0; taken = 0; stop = 0; gap = 0;
      for (int s = 0; s < NC; s++) begin
        if (valid_i[s]) begin
          if (gap) m_proto = 1;
          if (!stop) begin
            ec[s] = 1'b1;
            eo[s] = (m_next + seen) % 256;
            taken++;
            loop = (pc_wdata_i[s] == pc_rdata_i[s]) &&
                   (inst_i[s][6:0] == 7'h6F || inst_i[s][6:0] == 7'h63);
            if (loop) m_streak = (m_streak < HR) ? m_streak + 1 : HR;
            else      m_streak = 0;
            if (m_streak == HR) stop = 1;
          end
          seen++;
        end else begin
          gap = 1;
        end
      end
      m_next = (m_next + taken) % 256;
      if (valid_i == '0) m_idle = (m_idle < TO) ? m_idle + 1 : TO;
      else               m_idle = 0;
      if (stop) begin
        m_mode = 1; m_halt = 1;
      end else if (m_idle == TO) begin
        m_mode = 2; m_dead = 1;
      end
    end
    @(posedge clk);
    #1;
    check_eq("commit", commit_o, ec);
    for (int s = 0; s < NC; s++) begin
      if (rst)        check_eq("order_rst", order_o[s], 0);
      else if (ec[s]) check_eq("order", order_o[s], eo[s]);
    end
    check_eq("halt", halt_o, m_halt);
    check_eq("deadlock", deadlock_o, m_dead);
    check_eq("proto_err", proto_err_o, m_proto);
    check_eq("retired", retired_o, m_next);
  endtask

  task automatic drive(input logic [NC-1:0] v, input int k0, input int k1, input logic [31:0] pc);
    valid_i = v;
    set_slot(0, k0, pc);
    set_slot(1, k1, pc + 32'd4);
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(2'b11, 0, 0, 32'h100);
    rst = 1'b0;
  endtask

  initial begin
    int plen, ploop, pidle, r, k0, k1;
    logic [31:0] pc;

    // Ordering across mixed bundle widths
    do_reset();
    drive(2'b11, 0, 0, 32'h200);
    check_eq("dir_ord0", order_o[0], 0);
    check_eq("dir_ord1", order_o[1], 1);
    drive(2'b01, 0, 0, 32'h208);
    check_eq("dir_ord2", order_o[0], 2);
    drive(2'b11, 0, 0, 32'h20c);
    check_eq("dir_ord3", order_o[0], 3);
    check_eq("dir_ord4", order_o[1], 4);
    check_eq("dir_retired5", retired_o, 5);

    // Non-prefix bundle still commits slot 1 at the current base
    drive(2'b10, 0, 0, 32'h300);
    check_eq("dir_proto", proto_err_o, 1);
    check_eq("dir_gap_commit", commit_o, 2'b10);
    check_eq("dir_gap_order", order_o[1], 5);

    // Two self-loop JALs in one bundle halt together
    valid_i = 2'b11;
    set_slot(0, 1, 32'h60);
    set_slot(1, 1, 32'h60);
    cycle();
    check_eq("dir_halt", halt_o, 1);
    check_eq("dir_halt_commit", commit_o, 2'b11);
    drive(2'b11, 0, 0, 32'h400);
    check_eq("dir_frozen", retired_o, 8);

    // Streak broken by an ordinary commit
    do_reset();
    drive(2'b01, 1, 0, 32'h60);
    drive(2'b01, 0, 0, 32'h64);
    drive(2'b01, 2, 0, 32'h68);
    check_eq("dir_nohalt", halt_o, 0);
    drive(2'b01, 2, 0, 32'h68);
    check_eq("dir_halt2", halt_o, 1);

    // Watchdog fires on the 16th idle edge
    do_reset();
    for (int i = 0; i < TO - 1; i++) drive(2'b00, 0, 0, 32'h0);
    check_eq("dir_dl_early", deadlock_o, 0);
    drive(2'b00, 0, 0, 32'h0);
    check_eq("dir_dl", deadlock_o, 1);
    drive(2'b11, 0, 0, 32'h500);
    check_eq("dir_dl_ignored", commit_o, 0);

    // Reset in the middle of a stream
    do_reset();
    drive(2'b11, 0, 0, 32'h600);
    drive(2'b11, 0, 0, 32'h608);
    rst = 1'b1;
    drive(2'b11, 0, 0, 32'h610);
    check_eq("dir_rst_commit", commit_o, 0);
    check_eq("dir_rst_retired", retired_o, 0);
    rst = 1'b0;
    drive(2'b01, 0, 0, 32'h618);
    check_eq("dir_post_rst_order", order_o[0], 0);

    // Randomized epochs; epoch 0 is long and loop-free so the order counter wraps
    for (int e = 0; e < 24; e++) begin
      do_reset();
      plen  = (e == 0) ? 320 : 60;
      ploop = (e == 0) ? 0 : (e % 4) * 12;
      pidle = (e % 3 == 2) ? 85 : 15;
      for (int c = 0; c < plen; c++) begin
        r  = $urandom_range(0, 99);
        pc = {$urandom_range(0, 255), 2'b00};
        k0 = ($urandom_range(0, 99) < ploop) ? $urandom_range(1, 2) : (($urandom_range(0, 1) == 1) ? 0 : $urandom_range(3, 4));
        k1 = ($urandom_range(0, 99) < ploop) ? $urandom_range(1, 2) : 0;
        if (r < pidle)      drive(2'b00, k0, k1, pc);
        else if (r < pidle + 3) drive(2'b10, k0, k1, pc);
        else if (r < pidle + (100 - pidle) / 2) drive(2'b01, k0, k1, pc);
        else                drive(2'b11, k0, k1, pc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
